// File: rtl/mem_stage_access_pkg.sv
// Shared types and constants for the MEM stage of the pipelined RV32 core.
// Holds the FSM encoding, the WB select codes, the default widths and a misalignment helper.
package mem_stage_access_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam int N_DEFAULT       = 32;
  localparam int TIMEOUT_DEFAULT = 16;

  // Word accesses only: any set low address bit on a memory op is a fault.
  function automatic logic misaligned_access(input logic memop, input logic [1:0] addr_lsb);
    return memop & (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are held stable until the one-cycle ack strobe.
interface mem_stage_access_if #(
  parameter int N = 32
);
  logic         dmem_req;
  logic         dmem_we;
  logic [N-1:0] dmem_addr;
  logic [N-1:0] dmem_wdata;
  logic [N-1:0] dmem_rdata;
  logic         dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_access_mem_wb_register.sv
// MEM/WB pipeline register: loads every cycle; a bubble keeps the data but
// clears the register-file write enable so the slot retires without effect.
module mem_wb_register #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble_i,
  input  logic [N-1:0] read_data_i,
  input  logic [N-1:0] alu_result_i,
  input  logic [N-1:0] pc_plus4_i,
  input  logic [4:0]   write_register_i,
  input  logic [1:0]   mem_to_reg_i,
  input  logic         reg_write_i,
  output logic [N-1:0] read_data_o,
  output logic [N-1:0] alu_result_o,
  output logic [N-1:0] pc_plus4_o,
  output logic [4:0]   write_register_o,
  output logic [1:0]   mem_to_reg_o,
  output logic         reg_write_o
);

  // MEM/WB bundle with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_o      <= '0;
      alu_result_o     <= '0;
      pc_plus4_o       <= '0;
      write_register_o <= 5'd0;
      mem_to_reg_o     <= 2'd0;
      reg_write_o      <= 1'b0;
    end else begin
      read_data_o      <= read_data_i;
      alu_result_o     <= alu_result_i;
      pc_plus4_o       <= pc_plus4_i;
      write_register_o <= write_register_i;
      mem_to_reg_o     <= mem_to_reg_i;
      reg_write_o      <= reg_write_i & ~bubble_i;
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: drives the data-memory handshake from EX/MEM, stalls the front of
// the pipe while an access is outstanding, resolves redirects and feeds MEM/WB.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       pc_plus_imm_in,
  input  logic [N-1:0]       pc_plus4_in,
  input  logic [N-1:0]       read_data2_in,
  input  logic [N-1:0]       alu_result_in,
  input  logic [4:0]         write_register_in,
  input  logic               jal_in,
  input  logic               branch_in,
  input  logic               zero_in,
  input  logic               mem_write_in,
  input  logic               mem_read_in,
  input  logic               reg_write_in,
  input  logic [1:0]         mem_to_reg_in,
  mem_stage_access_if.master dmem,
  output logic               stall,
  output logic               pc_src,
  output logic [N-1:0]       pc_target,
  output logic               bus_error,
  output logic [N-1:0]       read_data_out,
  output logic [N-1:0]       alu_result_out,
  output logic [N-1:0]       pc_plus4_out,
  output logic [4:0]         write_register_out,
  output logic [1:0]         mem_to_reg_out,
  output logic               reg_write_out
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [N-1:0]       addr_q, addr_d;
  logic [N-1:0]       wdata_q, wdata_d;
  logic               bus_error_q, bus_error_d;
  logic               stall_d;
  logic               bubble_d;
  logic [N-1:0]       wb_rdata_d;
  logic               memop;
  logic               misaligned;
  logic               timeout_hit;

  assign memop       = mem_read_in | mem_write_in;
  assign misaligned  = misaligned_access(memop, alu_result_in[1:0]);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // FSM state, timeout counter and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next-state, stall and writeback-bubble decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_error_d = 1'b0;
    stall_d     = 1'b0;
    bubble_d    = 1'b0;
    wb_rdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (misaligned) begin
          bus_error_d = 1'b1;
          bubble_d    = 1'b1;
        end else if (memop) begin
          // mem_write_in wins when both read and write are set
          stall_d  = 1'b1;
          bubble_d = 1'b1;
          state_d  = ST_BUSY;
          req_d    = 1'b1;
          we_d     = mem_write_in;
          addr_d   = alu_result_in;
          wdata_d  = read_data2_in;
        end else begin
          bubble_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack) begin
          wb_rdata_d = dmem.dmem_rdata;
          req_d      = 1'b0;
          state_d    = ST_IDLE;
          cnt_d      = '0;
        end else if (timeout_hit) begin
          // Abort: release the pipe and retire the instruction as a no-op
          bubble_d    = 1'b1;
          bus_error_d = 1'b1;
          req_d       = 1'b0;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          stall_d  = 1'b1;
          bubble_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        req_d    = 1'b0;
        bubble_d = 1'b1;
      end
    endcase
  end

  assign stall      = stall_d;
  assign pc_src     = (jal_in | (branch_in & zero_in)) & ~stall_d;
  assign pc_target  = pc_plus_imm_in;
  assign bus_error  = bus_error_q;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  mem_wb_register #(.N(N)) u_mem_wb (
    .clk              (clk),
    .reset            (reset),
    .bubble_i         (bubble_d),
    .read_data_i      (wb_rdata_d),
    .alu_result_i     (alu_result_in),
    .pc_plus4_i       (pc_plus4_in),
    .write_register_i (write_register_in),
    .mem_to_reg_i     (mem_to_reg_in),
    .reg_write_i      (reg_write_in),
    .read_data_o      (read_data_out),
    .alu_result_o     (alu_result_out),
    .pc_plus4_o       (pc_plus4_out),
    .write_register_o (write_register_out),
    .mem_to_reg_o     (mem_to_reg_out),
    .reg_write_o      (reg_write_out)
  );

endmodule
